spi_cfg_regs: RTL
=================

Name: spi_cfg_regs

Overview:
- SPI-slave configuration register file for the mixer datapath; replaces the hard-wired volume constant feeding the mixer's vol_i.
- Oversamples an external SPI bus on clk245760 and decodes 24-bit frames into register reads and writes.
- Drives per-slot volume words and a global mute, and exposes S/PDIF receiver status (lock, rate) for readback.

Parameters:
- NUM_CH, 1, number of stereo input channels; 2*NUM_CH volume slots.
- VOL_RESET, 16'h00ff, reset value of every volume slot.
- ID_VALUE, 16'hda01, read-only identification word at address 0x00.

Ports:
- clk245760  in  1  system clock, 24.576 MHz.
- rst  in  1  reset, synchronous, active-high.
- spi_sclk_i  in  1  SPI clock, asynchronous, mode 0 (CPOL=0, CPHA=0).
- spi_mosi_i  in  1  SPI data in, asynchronous.
- spi_ss_i  in  1  SPI slave select, active-low, asynchronous.
- spi_miso_o  out  1  SPI data out.
- locked_i  in  NUM_CH  per-channel S/PDIF lock status.
- rate_i  in  4*NUM_CH  per-channel detected rate code; channel c occupies [4c+3:4c].
- vol_o  out  NUM_CH*2*16  volume words; slot k occupies [16k+15:16k]; slot 2c is ch c left, slot 2c+1 is ch c right.
- mute_o  out  1  global mute request to the mixer.

Behaviour:
- Input synchronization:
  - sclk, mosi and ss each pass through a 2-FF synchronizer, plus one history flop on sclk and ss for edge detection.
  - Rising/falling sclk events are single-cycle pulses.
  - Supported sclk ≤ clk245760/8; each sclk phase is ≥4 clk.
- Frame format, MSB first:
  - 8-bit command: bit7 W (1=write, 0=read), bits6:0 address.
  - Then 16-bit data, 24 bits total.
- FSM states IDLE, CMD, DATA, SKIP:
  - IDLE: synchronized ss high. ss falling → CMD with bitcnt=0.
  - CMD: sample mosi on each sclk rise into the shift register.
    - After the 8th rise, latch the command and go to DATA.
    - For reads, load the read shadow from the addressed register in the same cycle.
  - DATA: sample mosi on each sclk rise. After the 24th rise (bitcnt==23), go to SKIP.
    - If W and the address is writable, commit the write on the next clk.
    - Latency: vol_o/mute_o change exactly 1 clk after the synchronized 24th rise edge.
  - SKIP: further sclk edges are ignored until ss rises.
  - Any state: synchronized ss rising → IDLE. A frame aborted before bit 24 performs no write; a read has no side effects.
- MISO:
  - Driven 0 in IDLE, CMD and SKIP.
  - In DATA, drives shadow[15] after the latching cycle, then shifts the shadow left on each sclk fall.
  - Reset value 0.
- Register map:
  - 0x00 ID: RO, ID_VALUE.
  - 0x01 STATUS: RO. Bits [NUM_CH-1:0] = locked_i; bits [15:8] = rate_i of ch0 and ch1, zero-padded. Sampled when the read shadow loads.
  - 0x02 CTRL: RW. Bit0 = mute; other bits read 0.
  - 0x10+k for k < 2*NUM_CH: VOL slot k, RW, 16 bits.
  - Unmapped addresses read 16'h0000; writes to them are ignored.
  - Writes to RO registers are ignored.
- Reset values:
  - Every vol_o slot = VOL_RESET; mute_o = 0; spi_miso_o = 0; FSM = IDLE.
  - Synchronizer flops reset to the idle bus level (ss=1, sclk=0).
- Simultaneous events:
  - rst wins over a commit.
  - ss rise in the same clk as the 24th rise: the 24th rise is processed, then IDLE; the write still commits.
- Reset mid-frame: frame discarded. After rst deasserts, the block waits for a fresh ss falling edge. Any bits of an ongoing frame are not decoded, because ss must first be seen high.
- vol_o and mute_o are registered outputs with no glitches. All slots of a single frame update in the same clk.

Decomposition:
- Shared package dmix_cfg_pkg holds:
  - register address constants (ADDR_ID, ADDR_STATUS, ADDR_CTRL, ADDR_VOL_BASE);
  - command bit position W_BIT=7;
  - frame length 24.
- One sub-module, spi_slave_if: synchronizers, edge detect, FSM, shift registers. It presents wr_stb/addr/wdata and rd_req/rdata to the register-file logic in spi_cfg_regs.

Test Plan:
- Reset: assert rst for 4 clk → vol_o = {2{16'h00ff}} (NUM_CH=1), mute_o=0, miso=0; read 0x00 with sclk=clk/8 → MISO returns 16'hda01.
- Write 0x90,0x1234 (addr 0x10) → vol_o[15:0]=16'h1234 one clk after the synced 24th rise; vol_o[31:16] stays 16'h00ff; read back 0x10 → 16'h1234.
- Abort: write 0x91 + 8 data bits, then raise ss → vol_o unchanged; next full write 0x91,0xabcd → vol_o[31:16]=16'habcd.
- STATUS: locked_i=1, rate_i=4'h3; read 0x01 → 16'h0301; toggle locked_i to 0 mid-frame after the command byte → still returns 16'h0301.
- Mute and unmapped access: write 0x82,0x0001 → mute_o=1; write 0xff,0xffff → no output changes; read 0x7f → 16'h0000; 30-bit frame writing 0x82,0x0000 → mute_o=0, extra 6 bits ignored.
- Reset mid-frame: assert rst after 12 bits of a write to 0x10 → no commit; following bits until ss rise ignored; vol_o = 16'h00ff.

Source files
------------

// File: rtl/dmix_cfg_pkg.sv
// -----------------------------------------------------------------------------
// dmix_cfg_pkg
// Shared definitions for the mixer configuration register file: register
// addresses, SPI frame geometry and the SPI slave FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package dmix_cfg_pkg;

    // Register map (7-bit addresses)
    localparam logic [6:0] ADDR_ID       = 7'h00;
    localparam logic [6:0] ADDR_STATUS   = 7'h01;
    localparam logic [6:0] ADDR_CTRL     = 7'h02;
    localparam logic [6:0] ADDR_VOL_BASE = 7'h10;

    // Frame geometry: 8-bit command (W + address) then 16 data bits, MSB first
    localparam int         W_BIT      = 7;
    localparam int         FRAME_LEN  = 24;
    localparam logic [4:0] CMD_LEN    = 5'd8;
    localparam logic [4:0] CMD_LAST   = 5'd7;
    localparam logic [4:0] FRAME_LAST = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_SKIP = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_cfg_regs_if.sv
// -----------------------------------------------------------------------------
// spi_cfg_regs_if
// SPI bus bundle between an external master and the configuration slave.
//   spi_sclk_i  : SPI clock, mode 0, asynchronous to the system clock
//   spi_mosi_i  : master-out data
//   spi_ss_i    : slave select, active-low
//   spi_miso_o  : slave-out data
// -----------------------------------------------------------------------------
interface spi_cfg_regs_if;
    logic spi_sclk_i;
    logic spi_mosi_i;
    logic spi_ss_i;
    logic spi_miso_o;

    modport master (
        output spi_sclk_i,
        output spi_mosi_i,
        output spi_ss_i,
        input  spi_miso_o
    );

    modport slave (
        input  spi_sclk_i,
        input  spi_mosi_i,
        input  spi_ss_i,
        output spi_miso_o
    );
endinterface

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// Oversampling SPI mode-0 slave. Synchronizes the bus into clk245760, detects
// sclk/ss edges and decodes 24-bit frames into a write strobe and a read
// request toward the register file.
//   clk245760, rst : system clock, synchronous active-high reset
//   spi            : SPI bus (slave side), MISO is registered here
//   o_wr_stb       : one-cycle write request on the 24th sclk rise of a write
//   o_wr_addr/data : write address and data, valid with o_wr_stb
//   o_rd_req       : one-cycle read request when a read command is latched
//   o_rd_addr      : read address, valid with o_rd_req
//   i_rd_data      : read data returned combinationally for o_rd_addr
// -----------------------------------------------------------------------------
module spi_slave_if
    import dmix_cfg_pkg::*;
(
    input  logic                 clk245760,
    input  logic                 rst,
    spi_cfg_regs_if.slave        spi,
    output logic                 o_wr_stb,
    output logic [6:0]           o_wr_addr,
    output logic [15:0]          o_wr_data,
    output logic                 o_rd_req,
    output logic [6:0]           o_rd_addr,
    input  logic [15:0]          i_rd_data
);

    logic       r_sclk_meta, r_sclk_sync, r_sclk_hist;
    logic       r_ss_meta, r_ss_sync, r_ss_hist;
    logic       r_mosi_meta, r_mosi_sync;
    logic [1:0] r_settle;
    logic       r_armed;

    spi_state_e r_state, w_state_nxt;
    logic [4:0]  r_bitcnt, w_bitcnt_nxt;
    logic [15:0] r_shift, w_shift_nxt;
    logic [7:0]  r_cmd, w_cmd_nxt;
    logic [15:0] r_shadow, w_shadow_nxt;
    logic        r_miso, w_miso_nxt;

    logic        w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
    logic [15:0] w_shift_in;

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_hist;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_hist;
    assign w_ss_fall   = ~r_ss_sync & r_ss_hist;
    assign w_ss_rise   = r_ss_sync & ~r_ss_hist;
    assign w_shift_in  = {r_shift[14:0], r_mosi_sync};

    assign o_wr_addr      = r_cmd[6:0];
    assign o_wr_data      = w_shift_in;
    assign o_rd_addr      = w_shift_in[6:0];
    assign spi.spi_miso_o = r_miso;

    // Input synchronizers and edge-history flops, reset to the idle bus level
    always_ff @(posedge clk245760) begin
        if (rst) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_hist <= 1'b0;
            r_ss_meta   <= 1'b1;
            r_ss_sync   <= 1'b1;
            r_ss_hist   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sclk_meta <= spi.spi_sclk_i;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_hist <= r_sclk_sync;
            r_ss_meta   <= spi.spi_ss_i;
            r_ss_sync   <= r_ss_meta;
            r_ss_hist   <= r_ss_sync;
            r_mosi_meta <= spi.spi_mosi_i;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // Arm frame start only once ss has genuinely been seen high after reset;
    // the forced-high reset value of the ss flops would otherwise fake a
    // falling edge when rst is released in the middle of a frame.
    always_ff @(posedge clk245760) begin
        if (rst) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
            if ((r_settle == 2'd3) && r_ss_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Frame FSM next-state, shift/shadow update and decode strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_cmd_nxt    = r_cmd;
        w_shadow_nxt = r_shadow;
        w_miso_nxt   = r_miso;
        o_wr_stb     = 1'b0;
        o_rd_req     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_miso_nxt = 1'b0;
                if (r_armed && w_ss_fall) begin
                    w_state_nxt  = ST_CMD;
                    w_bitcnt_nxt = 5'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CMD: begin
                w_miso_nxt = 1'b0;
                if (w_sclk_rise) begin
                    w_shift_nxt  = w_shift_in;
                    w_bitcnt_nxt = r_bitcnt + 5'd1;
                    if (r_bitcnt == CMD_LAST) begin
                        w_cmd_nxt   = w_shift_in[7:0];
                        w_state_nxt = ST_DATA;
                        if (!w_shift_in[W_BIT]) begin
                            o_rd_req     = 1'b1;
                            w_shadow_nxt = i_rd_data;
                            w_miso_nxt   = i_rd_data[15];
                        end else begin
                            w_shadow_nxt = 16'h0000;
                        end
                    end else begin
                        w_state_nxt = ST_CMD;
                    end
                end else begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_DATA: begin
                if (w_sclk_rise) begin
                    w_shift_nxt  = w_shift_in;
                    w_bitcnt_nxt = r_bitcnt + 5'd1;
                    if (r_bitcnt == FRAME_LAST) begin
                        o_wr_stb    = r_cmd[W_BIT];
                        w_state_nxt = ST_SKIP;
                        w_miso_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else if (w_sclk_fall && (r_bitcnt > CMD_LEN)) begin
                    // The fall right after the command byte is skipped so
                    // the master sees shadow[15] on the first data rise.
                    w_shadow_nxt = {r_shadow[14:0], 1'b0};
                    w_miso_nxt   = r_shadow[14];
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_SKIP: begin
                w_miso_nxt  = 1'b0;
                w_state_nxt = ST_SKIP;
            end
            default: begin
                w_miso_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // ss release ends any frame; a coincident 24th rise was handled above
        if (w_ss_rise) begin
            w_state_nxt = ST_IDLE;
            w_miso_nxt  = 1'b0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge clk245760) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= 5'd0;
            r_shift  <= 16'h0000;
            r_cmd    <= 8'h00;
            r_shadow <= 16'h0000;
            r_miso   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_cmd    <= w_cmd_nxt;
            r_shadow <= w_shadow_nxt;
            r_miso   <= w_miso_nxt;
        end
    end

endmodule

// File: rtl/spi_cfg_regs.sv
// -----------------------------------------------------------------------------
// spi_cfg_regs
// SPI-configurable register file for the mixer: per-slot volume words, a
// global mute and read-only ID / S/PDIF status words.
//   clk245760, rst : system clock, synchronous active-high reset
//   spi            : SPI bus (slave side)
//   locked_i       : per-channel S/PDIF lock
//   rate_i         : per-channel rate code, channel c at [4c+3:4c]
//   vol_o          : volume slots, slot k at [16k+15:16k] (2c = L, 2c+1 = R)
//   mute_o         : global mute
// -----------------------------------------------------------------------------
module spi_cfg_regs
    import dmix_cfg_pkg::*;
#(
    parameter int          NUM_CH    = 1,
    parameter logic [15:0] VOL_RESET = 16'h00ff,
    parameter logic [15:0] ID_VALUE  = 16'hda01
) (
    input  logic                   clk245760,
    input  logic                   rst,
    spi_cfg_regs_if.slave          spi,
    input  logic [NUM_CH-1:0]      locked_i,
    input  logic [4*NUM_CH-1:0]    rate_i,
    output logic [NUM_CH*32-1:0]   vol_o,
    output logic                   mute_o
);

    localparam int NSLOT   = 2 * NUM_CH;
    localparam int RATE_W  = (4 * NUM_CH < 8) ? 4 * NUM_CH : 8;

    logic                 w_wr_stb;
    logic [6:0]           w_wr_addr;
    logic [15:0]          w_wr_data;
    logic                 w_rd_req;
    logic [6:0]           w_rd_addr;
    logic [15:0]          w_rd_data;
    logic [15:0]          w_status;
    logic [7:0]           w_rate8;
    logic [NSLOT*16-1:0]  r_vol;
    logic                 r_mute;

    spi_slave_if u_slave (
        .clk245760 (clk245760),
        .rst       (rst),
        .spi       (spi),
        .o_wr_stb  (w_wr_stb),
        .o_wr_addr (w_wr_addr),
        .o_wr_data (w_wr_data),
        .o_rd_req  (w_rd_req),
        .o_rd_addr (w_rd_addr),
        .i_rd_data (w_rd_data)
    );

    // Rate codes of ch0/ch1 zero-padded into the upper status byte
    assign w_rate8 = 8'(rate_i[RATE_W-1:0]);

    // STATUS word: lock bits low, rate byte high
    always_comb begin
        w_status                = 16'h0000;
        w_status[NUM_CH-1:0]    = locked_i;
        w_status[15:8]          = w_rate8;
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        w_rd_data = 16'h0000;
        if (w_rd_req) begin
            case (w_rd_addr)
                ADDR_ID:     w_rd_data = ID_VALUE;
                ADDR_STATUS: w_rd_data = w_status;
                ADDR_CTRL:   w_rd_data = {15'h0000, r_mute};
                default: begin
                    for (int k = 0; k < NSLOT; k++) begin
                        if (w_rd_addr == (ADDR_VOL_BASE + 7'(k))) begin
                            w_rd_data = r_vol[16*k +: 16];
                        end else begin
                            w_rd_data = w_rd_data;
                        end
                    end
                end
            endcase
        end else begin
            w_rd_data = 16'h0000;
        end
    end

    // Writable registers; reset takes priority over a commit
    always_ff @(posedge clk245760) begin
        if (rst) begin
            r_vol  <= {NSLOT{VOL_RESET}};
            r_mute <= 1'b0;
        end else if (w_wr_stb) begin
            if (w_wr_addr == ADDR_CTRL) begin
                r_mute <= w_wr_data[0];
            end
            for (int k = 0; k < NSLOT; k++) begin
                if (w_wr_addr == (ADDR_VOL_BASE + 7'(k))) begin
                    r_vol[16*k +: 16] <= w_wr_data;
                end
            end
        end
    end

    assign vol_o  = r_vol;
    assign mute_o = r_mute;

endmodule
